fc_l2_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one FC-side L2 TCDM-style master port (req/gnt/r_valid) among
//  NB_REQ requesters (FC data path, debug access, DMA-lite). Tracks in-flight transactions in an
//  ID FIFO so each in-order L2 response is routed back to its issuer. Sits between requesters and
//  the L2 data demux, upstream of the L2 interconnect.

---
 rtl/fc_l2_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fc_l2_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one FC-side L2 master port among NB_REQ requesters.
// In-flight transaction IDs are queued so in-order L2 responses return to their issuer.
module fc_l2_port_arbiter #(
    parameter int NB_REQ          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]     add_i,
    input  logic [NB_REQ-1:0]                wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]     wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0]   be_i,
    output logic [NB_REQ-1:0]                gnt_o,
    output logic [NB_REQ-1:0]                r_valid_o,
    output logic [DATA_WIDTH-1:0]            r_rdata_o,
    output logic                             l2_req_o,
    output logic [ADDR_WIDTH-1:0]            l2_add_o,
    output logic                             l2_wen_o,
    output logic [DATA_WIDTH-1:0]            l2_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          l2_be_o,
    input  logic                             l2_gnt_i,
    input  logic                             l2_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            l2_r_rdata_i,
    output logic                             err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W:0]   NB_W     = (IDX_W+1)'(NB_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_sel_q, lock_sel_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] scan_sel_s;
    logic             found_s;
    logic [IDX_W-1:0] sel_s;
    logic             push_s;
    logic             pop_s;
    logic [IDX_W-1:0] head_s;

    // Round-robin scan starting at the rr pointer, wrapping modulo NB_REQ.
    always_comb begin
        scan_sel_s = rr_ptr_q;
        found_s    = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            logic [IDX_W:0]   sum_v;
            logic [IDX_W-1:0] cand_v;
            sum_v = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (sum_v >= NB_W) begin
                sum_v = sum_v - NB_W;
            end else begin
                sum_v = sum_v;
            end
            cand_v = sum_v[IDX_W-1:0];
            if (!found_s && req_i[cand_v]) begin
                scan_sel_s = cand_v;
                found_s    = 1'b1;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Port request, payload mux and grant/response routing.
    always_comb begin
        sel_s      = lock_q ? lock_sel_q : scan_sel_s;
        l2_req_o   = !rst_i && (|req_i) && (count_q < MAX_CNT);
        push_s     = l2_req_o && l2_gnt_i;
        pop_s      = l2_r_valid_i && (count_q != {CNT_W{1'b0}});
        head_s     = fifo_q[rd_ptr_q];
        r_rdata_o  = l2_r_rdata_i;
        gnt_o      = {NB_REQ{1'b0}};
        r_valid_o  = {NB_REQ{1'b0}};
        l2_add_o   = {ADDR_WIDTH{1'b0}};
        l2_wen_o   = 1'b1;
        l2_wdata_o = {DATA_WIDTH{1'b0}};
        l2_be_o    = {BE_W{1'b0}};
        if (l2_req_o) begin
            l2_add_o   = add_i[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
            l2_wen_o   = wen_i[sel_s];
            l2_wdata_o = wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];
            l2_be_o    = be_i[sel_s*BE_W +: BE_W];
        end else begin
            l2_wen_o   = 1'b1;
        end
        if (push_s) begin
            gnt_o[sel_s] = 1'b1;
        end else begin
            gnt_o = {NB_REQ{1'b0}};
        end
        if (pop_s) begin
            r_valid_o[head_s] = 1'b1;
        end else begin
            r_valid_o = {NB_REQ{1'b0}};
        end
    end

    // Next-state for rr pointer, lock, ID FIFO and error flag.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q || (l2_r_valid_i && (count_q == {CNT_W{1'b0}}));
        if (l2_req_o && !l2_gnt_i) begin
            lock_d     = 1'b1;
            lock_sel_d = sel_s;
        end else if (push_s) begin
            lock_d     = 1'b0;
        end else begin
            lock_d     = lock_q;
        end
        if (push_s) begin
            fifo_d[wr_ptr_q] = sel_s;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rr_ptr_d         = (sel_s == LAST_IDX) ? {IDX_W{1'b0}} : sel_s + 1'b1;
        end else begin
            wr_ptr_d         = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every in-flight ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= {IDX_W{1'b0}};
            lock_q     <= 1'b0;
            lock_sel_q <= {IDX_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= {IDX_W{1'b0}};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Directed testbench for fc_l2_port_arbiter with two requesters and four outstanding slots.
module tb_fc_l2_port_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [63:0] add_i;
    logic [1:0]  wen_i;
    logic [63:0] wdata_i;
    logic [7:0]  be_i;
    logic [1:0]  gnt_o;
    logic [1:0]  r_valid_o;
    logic [31:0] r_rdata_o;
    logic        l2_req_o;
    logic [31:0] l2_add_o;
    logic        l2_wen_o;
    logic [31:0] l2_wdata_o;
    logic [3:0]  l2_be_o;
    logic        l2_gnt_i;
    logic        l2_r_valid_i;
    logic [31:0] l2_r_rdata_i;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'hBBBB_1111;
    localparam logic [3:0]  B0 = 4'h3;
    localparam logic [3:0]  B1 = 4'hC;

    fc_l2_port_arbiter #(
        .NB_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .l2_req_o(l2_req_o), .l2_add_o(l2_add_o),
        .l2_wen_o(l2_wen_o), .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o),
        .l2_gnt_i(l2_gnt_i), .l2_r_valid_i(l2_r_valid_i), .l2_r_rdata_i(l2_r_rdata_i),
        .err_o(err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        req_i        = req;
        l2_gnt_i     = gnt;
        l2_r_valid_i = rv;
        l2_r_rdata_i = rd;
        #1;
    endtask

    logic [31:0] rdat [4];
    logic [1:0]  rexp [4];

    initial begin
        rst_i   = 1'b1;
        add_i   = {A1, A0};
        wdata_i = {W1, W0};
        be_i    = {B1, B0};
        wen_i   = 2'b11;
        drv(2'b11, 1'b1, 1'b0, 32'h0);
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_l2_req", {31'd0, l2_req_o}, 32'd0);
        chk("rst_wen", {31'd0, l2_wen_o}, 32'd1);
        chk("rst_add", l2_add_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rvalid", {30'd0, r_valid_o}, 32'd0);
        nxt();
        nxt();
        rst_i = 1'b0;
        drv(2'b00, 1'b0, 1'b0, 32'h0);

        // 1: round-robin alternation with continuous grants
        nxt(); drv(2'b11, 1'b1, 1'b0, 32'h0);
        chk("rr_g0", {30'd0, gnt_o}, 32'd1);
        chk("rr_add0", l2_add_o, A0);
        nxt(); drv(2'b11, 1'b1, 1'b1, 32'h11);
        chk("rr_g1", {30'd0, gnt_o}, 32'd2);
        chk("rr_rv1", {30'd0, r_valid_o}, 32'd1);
        nxt();
        chk("rr_g2", {30'd0, gnt_o}, 32'd1);
        chk("rr_rv2", {30'd0, r_valid_o}, 32'd2);
        nxt();
        chk("rr_g3", {30'd0, gnt_o}, 32'd2);
        chk("rr_rv3", {30'd0, r_valid_o}, 32'd1);
        nxt(); drv(2'b00, 1'b0, 1'b1, 32'h22);
        chk("rr_rv4", {30'd0, r_valid_o}, 32'd2);
        chk("idle_req", {31'd0, l2_req_o}, 32'd0);
        chk("idle_add", l2_add_o, 32'd0);
        chk("idle_wen", {31'd0, l2_wen_o}, 32'd1);

        // 2: lock holds requester 1 while ungranted
        nxt(); drv(2'b10, 1'b0, 1'b0, 32'h0);
        chk("lk_add1", l2_add_o, A1);
        chk("lk_gnt1", {30'd0, gnt_o}, 32'd0);
        nxt(); drv(2'b11, 1'b0, 1'b0, 32'h0);
        chk("lk_add2", l2_add_o, A1);
        nxt();
        chk("lk_add3", l2_add_o, A1);
        nxt(); drv(2'b11, 1'b1, 1'b0, 32'h0);
        chk("lk_gnt4", {30'd0, gnt_o}, 32'd2);
        chk("lk_add4", l2_add_o, A1);
        nxt();
        chk("lk_gnt5", {30'd0, gnt_o}, 32'd1);
        chk("lk_add5", l2_add_o, A0);
        nxt(); drv(2'b00, 1'b0, 1'b1, 32'h0);
        chk("lk_rv0", {30'd0, r_valid_o}, 32'd2);
        nxt();
        chk("lk_rv1", {30'd0, r_valid_o}, 32'd1);

        // 3: fill to MAX_OUTSTANDING; slot freed only the cycle after a pop
        nxt(); drv(2'b01, 1'b1, 1'b0, 32'h0);
        chk("full_g0", {30'd0, gnt_o}, 32'd1);
        nxt(); nxt(); nxt();
        chk("full_g3", {30'd0, gnt_o}, 32'd1);
        nxt();
        chk("full_req", {31'd0, l2_req_o}, 32'd0);
        chk("full_gnt", {30'd0, gnt_o}, 32'd0);
        drv(2'b01, 1'b1, 1'b1, 32'h33);
        chk("full_pop_req", {31'd0, l2_req_o}, 32'd0);
        chk("full_pop_rv", {30'd0, r_valid_o}, 32'd1);
        nxt(); drv(2'b01, 1'b1, 1'b0, 32'h0);
        chk("full_reissue", {31'd0, l2_req_o}, 32'd1);
        chk("full_regnt", {30'd0, gnt_o}, 32'd1);
        nxt(); drv(2'b00, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_rv", {30'd0, r_valid_o}, 32'd1);
            nxt();
        end

        // 4: grants 0,1,1,0 then in-order responses
        drv(2'b01, 1'b1, 1'b0, 32'h0);
        chk("io_g0", {30'd0, gnt_o}, 32'd1);
        nxt(); drv(2'b10, 1'b1, 1'b0, 32'h0);
        chk("io_g1", {30'd0, gnt_o}, 32'd2);
        nxt(); wen_i = 2'b01; drv(2'b10, 1'b1, 1'b0, 32'h0);
        chk("io_g2", {30'd0, gnt_o}, 32'd2);
        chk("wr_wen", {31'd0, l2_wen_o}, 32'd0);
        chk("wr_wdata", l2_wdata_o, W1);
        chk("wr_be", {28'd0, l2_be_o}, {28'd0, B1});
        nxt(); wen_i = 2'b11; drv(2'b01, 1'b1, 1'b0, 32'h0);
        chk("io_g3", {30'd0, gnt_o}, 32'd1);
        chk("rd_wen", {31'd0, l2_wen_o}, 32'd1);
        rdat[0] = 32'hD000_0000; rdat[1] = 32'hD111_1111;
        rdat[2] = 32'hD222_2222; rdat[3] = 32'hD333_3333;
        rexp[0] = 2'b01; rexp[1] = 2'b10; rexp[2] = 2'b10; rexp[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            nxt(); drv(2'b00, 1'b0, 1'b1, rdat[i]);
            chk("io_rv", {30'd0, r_valid_o}, {30'd0, rexp[i]});
            chk("io_rdata", r_rdata_o, rdat[i]);
        end

        // 5: push and pop together at count 2
        nxt(); drv(2'b01, 1'b1, 1'b0, 32'h0);
        nxt(); drv(2'b10, 1'b1, 1'b0, 32'h0);
        nxt(); drv(2'b01, 1'b1, 1'b1, 32'h5555_5555);
        chk("pp_gnt", {30'd0, gnt_o}, 32'd1);
        chk("pp_rv", {30'd0, r_valid_o}, 32'd1);
        nxt(); drv(2'b00, 1'b0, 1'b1, 32'h0);
        chk("pp_rv1", {30'd0, r_valid_o}, 32'd2);
        nxt();
        chk("pp_rv2", {30'd0, r_valid_o}, 32'd1);

        // 6: response with empty FIFO, then reset mid-burst
        nxt();
        chk("emp_rv", {30'd0, r_valid_o}, 32'd0);
        chk("emp_err_pre", {31'd0, err_o}, 32'd0);
        nxt(); drv(2'b00, 1'b0, 1'b0, 32'h0);
        chk("emp_err", {31'd0, err_o}, 32'd1);
        nxt();
        chk("emp_err_held", {31'd0, err_o}, 32'd1);
        drv(2'b01, 1'b1, 1'b0, 32'h0);
        nxt(); drv(2'b11, 1'b1, 1'b0, 32'h0);
        rst_i = 1'b1;
        #1;
        chk("mr_gnt", {30'd0, gnt_o}, 32'd0);
        chk("mr_req", {31'd0, l2_req_o}, 32'd0);
        chk("mr_err", {31'd0, err_o}, 32'd0);
        nxt();
        rst_i = 1'b0;
        drv(2'b00, 1'b0, 1'b1, 32'h0);
        chk("mr_fifo_empty", {30'd0, r_valid_o}, 32'd0);
        nxt(); drv(2'b11, 1'b1, 1'b0, 32'h0);
        chk("mr_rr0", {30'd0, gnt_o}, 32'd1);
        nxt(); drv(2'b00, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
